uart_tx: RTL

- Serial byte transmitter: accepts one byte over a valid/ready handshake and shifts it out on a single line as an 8N1 asynchronous frame.
- Sits between the Hack CPU's memory-mapped output register and the FPGA pin that drives the host link.
- It is the sending end of the host serial link; the host-side receiver samples the frame.

---
 rtl/uart_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 serial byte transmitter with valid/ready input handshake and registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bit_end = (cnt_reg == CNT_MAX);

    // tx_next is derived from the current state, so the line lags the state by one cycle.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = bit_end ? '0 : cnt_reg + 1'b1;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (valid) begin
                    state_next  = START;
                    shift_next  = data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data;
`endif
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = parity_reg;
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready = (state_reg == IDLE);
    assign busy  = ~ready;
    assign tx    = tx_reg;

endmodule
